ultrasonic_ranging_sequencer: RTL and testbench

- Schedules periodic ranging cycles for the ultrasonic proximity sensor.
- Per cycle: issues the trigger pulse, times the echo pulse, and converts its width to centimetres.
- Flags obstacles and echo timeouts for downstream motor control.
- Replaces free-running trigger generation with a single scheduled, reset-controlled sequencer.

---
 rtl/ultrasonic_ranging_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_ultrasonic_ranging_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranging_sequencer.sv
// Periodic trigger / echo-timing sequencer for an ultrasonic range sensor.
// Optional 3-sample median output filter enabled by defining RANGE_MEDIAN_EN.
module ultrasonic_ranging_sequencer #(
    parameter int unsigned TRIG_CYCLES         = 1000,
    parameter int unsigned CYCLES_PER_CM       = 5800,
    parameter int unsigned ECHO_TIMEOUT_CYCLES = 2500000,
    parameter int unsigned PERIOD_CYCLES       = 6000000,
    parameter int unsigned DIST_W              = 9,
    parameter int unsigned THRESH_CM           = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              echo_i,
    output logic              trigger_o,
    output logic [DIST_W-1:0] dist_cm_o,
    output logic              dist_valid_o,
    output logic              obstacle_o,
    output logic              timeout_o,
    output logic              busy_o
);

    localparam int unsigned TMR_MAX = (TRIG_CYCLES > ECHO_TIMEOUT_CYCLES) ? TRIG_CYCLES : ECHO_TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned SUB_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int unsigned PER_W   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q;
    logic [PER_W-1:0]    per_q;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic                echo_meta_q, echo_s_q, echo_dly_q;
    logic                trigger_q, valid_q, obst_q, tout_q, busy_q;
    logic [DIST_W-1:0]   dist_q;
    logic                rise_s, fall_s, per_end_s, wrap_s, tmr_exp_s;
    logic                report_s, tout_evt_s;
    state_e              next_cycle_s;
    logic [DIST_W-1:0]   dist_sel_s;

    assign rise_s       = echo_s_q & ~echo_dly_q;
    assign fall_s       = ~echo_s_q & echo_dly_q;
    assign per_end_s    = (per_q == PER_W'(PERIOD_CYCLES - 1));
    assign wrap_s       = (sub_q == SUB_W'(CYCLES_PER_CM - 1));
    assign tmr_exp_s    = (tmr_q == TMR_W'(ECHO_TIMEOUT_CYCLES - 1));
    assign next_cycle_s = en_i ? ST_TRIG : ST_IDLE;

`ifdef RANGE_MEDIAN_EN
    logic [DIST_W-1:0] win_q [3];
    logic [1:0]        fill_q;

    function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b,
                                               input logic [DIST_W-1:0] c);
        logic [DIST_W-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo) begin
            return lo;
        end else if (c >= hi) begin
            return hi;
        end else begin
            return c;
        end
    endfunction

    // The incoming sample plus the two newest stored samples form the 3-sample window.
    always_comb begin
        dist_sel_s = cm_q;
        if (fill_q >= 2'd2) begin
            dist_sel_s = med3(cm_q, win_q[0], win_q[1]);
        end else begin
            dist_sel_s = cm_q;
        end
    end

    // Window of recent valid distances; timeouts never enter it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q[0] <= '0;
            win_q[1] <= '0;
            win_q[2] <= '0;
            fill_q   <= 2'd0;
        end else if (report_s) begin
            win_q[0] <= cm_q;
            win_q[1] <= win_q[0];
            win_q[2] <= win_q[1];
            fill_q   <= (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
        end else begin
            fill_q   <= fill_q;
        end
    end
`else
    assign dist_sel_s = cm_q;
`endif

    // Next-state logic and echo-width counting.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        cm_d       = cm_q;
        report_s   = 1'b0;
        tout_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_TRIG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIG: begin
                if (tmr_q == TMR_W'(TRIG_CYCLES - 1)) begin
                    state_d = ST_WAIT_RISE;
                end else begin
                    state_d = ST_TRIG;
                end
            end
            ST_WAIT_RISE: begin
                if (rise_s) begin
                    // The rise cycle is itself the first cycle of echo width.
                    state_d = ST_MEASURE;
                    if (CYCLES_PER_CM == 1) begin
                        sub_d = '0;
                        cm_d  = DIST_W'(1);
                    end else begin
                        sub_d = SUB_W'(1);
                        cm_d  = '0;
                    end
                end else if (tmr_exp_s) begin
                    tout_evt_s = 1'b1;
                    state_d    = per_end_s ? next_cycle_s : ST_HOLDOFF;
                end else begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_MEASURE: begin
                if (fall_s) begin
                    report_s = 1'b1;
                    state_d  = per_end_s ? next_cycle_s : ST_HOLDOFF;
                end else if (tmr_exp_s) begin
                    tout_evt_s = 1'b1;
                    state_d    = per_end_s ? next_cycle_s : ST_HOLDOFF;
                end else if (wrap_s) begin
                    sub_d = '0;
                    if (cm_q != {DIST_W{1'b1}}) begin
                        cm_d = cm_q + DIST_W'(1);
                    end else begin
                        cm_d = cm_q;
                    end
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (per_end_s) begin
                    state_d = next_cycle_s;
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, echo synchroniser and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            per_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_dly_q  <= 1'b0;
            trigger_q   <= 1'b0;
            valid_q     <= 1'b0;
            obst_q      <= 1'b0;
            tout_q      <= 1'b0;
            busy_q      <= 1'b0;
            dist_q      <= '0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            echo_meta_q <= echo_i;
            echo_s_q    <= echo_meta_q;
            echo_dly_q  <= echo_s_q;
            if (state_d != state_q) begin
                tmr_q <= '0;
            end else if (tmr_q != TMR_W'(TMR_MAX - 1)) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end else begin
                tmr_q <= tmr_q;
            end
            if ((state_d == ST_TRIG) && (state_q != ST_TRIG)) begin
                per_q <= '0;
            end else if (!per_end_s) begin
                per_q <= per_q + PER_W'(1);
            end else begin
                per_q <= per_q;
            end
            trigger_q <= (state_d == ST_TRIG);
            busy_q    <= (state_d != ST_IDLE);
            valid_q   <= report_s | tout_evt_s;
            if (report_s) begin
                dist_q <= dist_sel_s;
                obst_q <= (32'(dist_sel_s) < 32'(THRESH_CM));
                tout_q <= 1'b0;
            end else if (tout_evt_s) begin
                tout_q <= 1'b1;
            end else begin
                tout_q <= tout_q;
            end
        end
    end

    assign trigger_o    = trigger_q;
    assign dist_cm_o    = dist_q;
    assign dist_valid_o = valid_q;
    assign obstacle_o   = obst_q;
    assign timeout_o    = tout_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_ultrasonic_ranging_sequencer.sv
// Directed self-checking bench for ultrasonic_ranging_sequencer (reduced timing parameters).
// Expectations for the median filter path follow RANGE_MEDIAN_EN when defined.
module tb_ultrasonic_ranging_sequencer;

    logic       clk, rst, en, echo;
    logic       trigger, dist_valid, obstacle, timeout, busy;
    logic [8:0] dist_cm;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc_r = 0, last_rise_r = 0, last_interval_r = 0, hi_len_r = 0, last_width_r = 0;
    int rise_cnt_r = 0, dv_cnt_r = 0;
    logic trig_prev_r = 1'b0;

    ultrasonic_ranging_sequencer #(
        .TRIG_CYCLES(10), .CYCLES_PER_CM(4), .ECHO_TIMEOUT_CYCLES(200),
        .PERIOD_CYCLES(400), .DIST_W(9), .THRESH_CM(20)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .echo_i(echo),
        .trigger_o(trigger), .dist_cm_o(dist_cm), .dist_valid_o(dist_valid),
        .obstacle_o(obstacle), .timeout_o(timeout), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trigger width / spacing and dist_valid pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc_r       <= cyc_r + 1;
        trig_prev_r <= trigger;
        if (trigger === 1'b1 && trig_prev_r === 1'b0) begin
            last_interval_r <= cyc_r - last_rise_r;
            last_rise_r     <= cyc_r;
            rise_cnt_r      <= rise_cnt_r + 1;
            hi_len_r        <= 1;
        end else if (trigger === 1'b1) begin
            hi_len_r <= hi_len_r + 1;
        end
        if (trigger === 1'b0 && trig_prev_r === 1'b1) last_width_r <= hi_len_r;
        if (dist_valid === 1'b1) dv_cnt_r <= dv_cnt_r + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_trig_fall();
        int k = 0;
        while (trigger !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        while (trigger !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) check("trig_wait_expired", 0, 1);
    endtask

    task automatic wait_dv(output int k);
        k = 0;
        while (dist_valid !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        if (k >= 1000) check("dv_wait_expired", 0, 1);
    endtask

    task automatic do_range(input int width, input int exp_cm, input logic exp_obs, input bit chk_int);
        int k;
        wait_trig_fall();
        repeat (30) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        wait_dv(k);
        check("dist_cm", 32'(dist_cm), 32'(exp_cm));
        check("obstacle", 32'(obstacle), 32'(exp_obs));
        check("timeout_clr", 32'(timeout), 0);
        if (chk_int) check("period", last_interval_r, 400);
        @(negedge clk);
        check("dv_single", 32'(dist_valid), 0);
    endtask

    initial begin
        int k;
        int exp4_cm;
        logic exp4_obs;
`ifdef RANGE_MEDIAN_EN
        exp4_cm = 30; exp4_obs = 1'b0;
`else
        exp4_cm = 5;  exp4_obs = 1'b1;
`endif
        rst = 1'b1; en = 1'b0; echo = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_dist", 32'(dist_cm), 0);
        check("rst_valid", 32'(dist_valid), 0);
        check("rst_obstacle", 32'(obstacle), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0; en = 1'b1;

        do_range(100, 25, 1'b0, 1'b0);
        check("trig_width", last_width_r, 10);
        do_range(40, 10, 1'b1, 1'b1);
        do_range(100, 25, 1'b0, 1'b1);

        // No echo at all.
        wait_trig_fall();
        wait_dv(k);
        check("noecho_latency", k, 200);
        check("noecho_timeout", 32'(timeout), 1);
        check("noecho_dist_held", 32'(dist_cm), 25);
        check("noecho_obst_held", 32'(obstacle), 0);
        check("period", last_interval_r, 400);

        // Echo stuck high through the trigger.
        echo = 1'b1;
        wait_trig_fall();
        wait_dv(k);
        check("stuck_latency", k, 200);
        check("stuck_timeout", 32'(timeout), 1);
        check("period", last_interval_r, 400);
        echo = 1'b0;

        // Drop enable during the measurement.
        wait_trig_fall();
        repeat (30) @(negedge clk);
        echo = 1'b1;
        repeat (20) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        echo = 1'b0;
        wait_dv(k);
        check("en_drop_dist", 32'(dist_cm), 10);
        check("en_drop_obst", 32'(obstacle), 1);
        check("en_drop_timeout", 32'(timeout), 0);
        check("period", last_interval_r, 400);
        repeat (450) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("trig_count", rise_cnt_r, 6);

        // Reset in the middle of a measurement.
        en = 1'b1;
        wait_trig_fall();
        repeat (30) @(negedge clk);
        echo = 1'b1;
        repeat (52) @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        check("mid_rst_trigger", 32'(trigger), 0);
        check("mid_rst_dist", 32'(dist_cm), 0);
        check("mid_rst_valid", 32'(dist_valid), 0);
        check("mid_rst_obstacle", 32'(obstacle), 0);
        check("mid_rst_timeout", 32'(timeout), 0);
        check("mid_rst_busy", 32'(busy), 0);
        echo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("dv_count", dv_cnt_r, 6);
        check("post_rst_busy", 32'(busy), 0);

        // Distance sequence 10, 45, 30, 5 from an empty window.
        en = 1'b1;
        do_range(40, 10, 1'b1, 1'b0);
        do_range(180, 45, 1'b0, 1'b1);
        do_range(120, 30, 1'b0, 1'b1);
        do_range(20, exp4_cm, exp4_obs, 1'b1);
        en = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
